// File: rtl/motor_cmd_sched.sv
// motor_cmd_sched: arm/disarm gate, watchdog and per-channel dispatch.
// Optional: CMD_CLAMP_EN clamps accepted targets to [MIN_SPEED, MAX_CMD].
module motor_cmd_sched #(
  parameter int unsigned NUM_CH         = 4,
  parameter logic [15:0] MIN_SPEED      = 16'd256,
  parameter logic [15:0] MAX_CMD        = 16'd65280,
  parameter int unsigned ARM_CYCLES     = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [NUM_CH*16-1:0]   cmd_speed,
  input  logic [NUM_CH-1:0]      ch_busy,
  output logic [NUM_CH*16-1:0]   ch_speed,
  output logic [NUM_CH-1:0]      ch_oe,
  output logic                   armed,
  output logic                   failsafe
);

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARM_WAIT,
    ST_ARMED,
    ST_FAILSAFE
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             arm_cnt_q, arm_cnt_d;
  logic [31:0]             wd_cnt_q, wd_cnt_d;
  logic [NUM_CH-1:0]       pend_q, pend_d;
  logic [NUM_CH-1:0][15:0] pnd_val_q, pnd_val_d;
  logic [NUM_CH-1:0]       hold_q, hold_d;
  logic [NUM_CH-1:0]       oe_q, oe_d;
  logic [NUM_CH-1:0][15:0] spd_q, spd_d;
  logic                    rdy_q, rdy_d;
  logic                    accept;
  logic                    safe_load;
  logic [NUM_CH-1:0]       fire;

`ifdef CMD_CLAMP_EN
  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (v < MIN_SPEED) return MIN_SPEED;
    if (v > MAX_CMD)   return MAX_CMD;
    return v;
  endfunction
`else
  function automatic logic [15:0] clamp(input logic [15:0] v);
    return v;
  endfunction
  logic unused_max;
  assign unused_max = ^MAX_CMD;
`endif

  assign cmd_ready = rdy_q;
  assign ch_oe     = oe_q;
  assign ch_speed  = spd_q;
  assign armed     = (state_q == ST_ARMED);
  assign failsafe  = (state_q == ST_FAILSAFE);

  assign accept = cmd_valid & rdy_q & (state_q == ST_ARMED);
  assign fire   = pend_q & ~ch_busy & ~hold_q;

  // Arm state machine, arming counter and command watchdog.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = 32'd0;
    wd_cnt_d  = 32'd0;
    rdy_d     = 1'b1;
    unique case (state_q)
      ST_DISARMED: begin
        if (arm) state_d = ST_ARM_WAIT;
      end
      ST_ARM_WAIT: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else if (arm_cnt_q == ARM_CYCLES - 1) begin
          state_d = ST_ARMED;
        end else begin
          arm_cnt_d = arm_cnt_q + 32'd1;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else if (accept) begin
          wd_cnt_d = 32'd0;
        end else if (wd_cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d = ST_FAILSAFE;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
      end
      ST_FAILSAFE: begin
        if (!arm) state_d = ST_DISARMED;
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  assign safe_load = (state_d != state_q) && (state_d != ST_ARMED);

  // Pending capture and per-channel one-shot dispatch with holdoff.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      oe_d[i]      = fire[i];
      hold_d[i]    = fire[i];
      spd_d[i]     = fire[i] ? pnd_val_q[i] : spd_q[i];
      pend_d[i]    = pend_q[i] & ~fire[i];
      pnd_val_d[i] = pnd_val_q[i];
      if (safe_load) begin
        pnd_val_d[i] = MIN_SPEED;
        pend_d[i]    = 1'b1;
      end else if (accept) begin
        pnd_val_d[i] = clamp(cmd_speed[i*16 +: 16]);
        pend_d[i]    = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DISARMED;
      arm_cnt_q <= '0;
      wd_cnt_q  <= '0;
      pend_q    <= '0;
      pnd_val_q <= {NUM_CH{MIN_SPEED}};
      hold_q    <= '0;
      oe_q      <= '0;
      spd_q     <= {NUM_CH{MIN_SPEED}};
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      pend_q    <= pend_d;
      pnd_val_q <= pnd_val_d;
      hold_q    <= hold_d;
      oe_q      <= oe_d;
      spd_q     <= spd_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_motor_cmd_sched.sv
// tb_motor_cmd_sched: scoreboard bench for motor_cmd_sched.
// Per-channel queues hold expected load values; strobes pop them.
module tb_motor_cmd_sched;

  localparam int          NCH  = 4;
  localparam logic [15:0] MINS = 16'd256;
  localparam logic [15:0] MAXC = 16'd60000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             arm;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [NCH*16-1:0] cmd_speed;
  logic [NCH-1:0]   ch_busy;
  logic [NCH*16-1:0] ch_speed;
  logic [NCH-1:0]   ch_oe;
  logic             armed;
  logic             failsafe;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0]    sb [NCH][$];
  logic [NCH-1:0] prev_oe = '0;

  always #5 clk = ~clk;

  motor_cmd_sched #(
    .NUM_CH(NCH),
    .MIN_SPEED(MINS),
    .MAX_CMD(MAXC),
    .ARM_CYCLES(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arm(arm),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_speed(cmd_speed),
    .ch_busy(ch_busy),
    .ch_speed(ch_speed),
    .ch_oe(ch_oe),
    .armed(armed),
    .failsafe(failsafe)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mdl(input logic [15:0] v);
`ifdef CMD_CLAMP_EN
    if (v < MINS) return MINS;
    if (v > MAXC) return MAXC;
`endif
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_all(input logic [15:0] v);
    for (int i = 0; i < NCH; i++) sb[i].push_back(v);
  endtask

  task automatic push_ch(input int i, input logic [15:0] v);
    sb[i].push_back(mdl(v));
  endtask

  task automatic drive(input logic [63:0] b);
    cmd_valid = 1'b1;
    cmd_speed = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] b);
    for (int i = 0; i < NCH; i++) push_ch(i, b[i*16 +: 16]);
    drive(b);
  endtask

  task automatic sb_empty(input string tag);
    for (int i = 0; i < NCH; i++)
      check($sformatf("%s_ch%0d", tag, i), sb[i].size(), 0);
  endtask

  // Strobe monitor: one-cycle width and scoreboard compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|(ch_oe & prev_oe))
        check("oe_width", ch_oe & prev_oe, 0);
      for (int i = 0; i < NCH; i++) begin
        if (ch_oe[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("spurious_oe_ch%0d", i), ch_oe[i], 0);
          end else begin
            logic [15:0] e;
            e = sb[i].pop_front();
            check($sformatf("load_ch%0d", i),
                  ch_speed[i*16 +: 16], e);
          end
        end
      end
    end
    prev_oe = ch_oe;
  end

  initial begin
    logic [63:0] exp_v;
    rst_n     = 1'b0;
    arm       = 1'b0;
    cmd_valid = 1'b0;
    cmd_speed = '0;
    ch_busy   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 0);
    check("rst_oe", ch_oe, 0);
    check("rst_speed", ch_speed, {NCH{MINS}});
    check("rst_armed", armed, 0);
    check("rst_fs", failsafe, 0);
    rst_n = 1'b1;
    tick();
    check("ready_first_edge", cmd_ready, 1);
    check("idle_armed", armed, 0);
    repeat (3) tick();
    check("idle_oe", ch_oe, 0);

    // arm dropped mid-wait
    arm = 1'b1;
    push_all(MINS);
    repeat (4) tick();
    check("abort_wait_armed", armed, 0);
    arm = 1'b0;
    push_all(MINS);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_armed", armed, 0);
    end
    sb_empty("abort_pulses");

    // full arming sequence
    arm = 1'b1;
    push_all(MINS);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("arm_wait_armed", armed, 0);
    end
    tick();
    check("armed_after_wait", armed, 1);
    sb_empty("arm_pulses");

    // busy channel holds its strobe
    ch_busy = 4'b0010;
    send({16'd4000, 16'd3000, 16'd2000, 16'd1000});
    check("busy_lat0", ch_oe, 0);
    tick();
    check("busy_oe", ch_oe, 4'b1101);
    tick();
    check("busy_oe_clr", ch_oe, 0);
    repeat (2) tick();
    check("busy_hold", ch_oe, 0);
    ch_busy = 4'b0000;
    tick();
    check("busy_release", ch_oe, 4'b0010);
    check("busy_release_val", ch_speed[31:16], 2000);
    tick();
    check("busy_release_clr", ch_oe, 0);

    // newest wins on a busy channel
    ch_busy = 4'b0001;
    for (int i = 1; i < NCH; i++) push_ch(i, 16'(10 + i));
    drive({16'd13, 16'd12, 16'd11, 16'd1000});
    send({16'd23, 16'd22, 16'd21, 16'd5000});
    repeat (3) tick();
    check("newest_blocked", ch_oe[0], 0);
    ch_busy = 4'b0000;
    tick();
    check("newest_oe", ch_oe[0], 1);
    check("newest_val", ch_speed[15:0], mdl(16'd5000));
    repeat (3) tick();
    sb_empty("newest");

    // watchdog timeout
    send({NCH{16'd500}});
    push_all(MINS);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("wd_armed", armed, k < 16);
      check("wd_fs", failsafe, k == 16);
    end
    repeat (3) tick();
    check("fs_speed", ch_speed, {NCH{MINS}});
    check("fs_sticky", failsafe, 1);
    sb_empty("fs");

    // disarm, rearm, accept on the timeout cycle
    arm = 1'b0;
    push_all(MINS);
    tick();
    check("disarm_fs", failsafe, 0);
    check("disarm_armed", armed, 0);
    arm = 1'b1;
    push_all(MINS);
    repeat (8) tick();
    check("rearm_wait", armed, 0);
    tick();
    check("rearmed", armed, 1);
    repeat (15) tick();
    send({16'd7, 16'd8, 16'd9, 16'd10});
    check("wd_accept_armed", armed, 1);
    check("wd_accept_fs", failsafe, 0);
    repeat (15) tick();
    check("wd_restart", armed, 1);

    // clamp / pass-through
    send({16'd65535, 16'd100, 16'd30000, 16'd256});
    check("clamp_armed", armed, 1);
    tick();
    check("clamp_oe", ch_oe, 4'hf);
`ifdef CMD_CLAMP_EN
    exp_v = {16'd60000, 16'd256, 16'd30000, 16'd256};
`else
    exp_v = {16'd65535, 16'd100, 16'd30000, 16'd256};
`endif
    check("clamp_val", ch_speed, exp_v);
    repeat (2) tick();
    sb_empty("final");

    // async reset in the middle of a dispatch
    send({NCH{16'd1234}});
    tick();
    check("pre_reset_oe", ch_oe, 4'hf);
    rst_n = 1'b0;
    #1;
    check("async_rst_oe", ch_oe, 0);
    check("async_rst_speed", ch_speed, {NCH{MINS}});
    check("async_rst_ready", cmd_ready, 0);
    check("async_rst_armed", armed, 0);
    for (int i = 0; i < NCH; i++) sb[i].delete();
    arm = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_oe", ch_oe, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
